// File: rtl/am_lock_pkg.sv
// am_lock_pkg: shared constants for the per-lane alignment-marker lock stage
//   - default AM period and bad-AM tolerance
//   - FSM state encoding
//   - Clause 82 AM byte table (M0..M2 per PCS lane; M4..M6 are their complements)
package am_lock_pkg;
  localparam int AM_PERIOD_DFLT  = 16384;
  localparam int MAX_INV_AM_DFLT = 4;
  localparam int N_LANES_DFLT    = 20;
  localparam logic [2:0] FIND_1ST = 3'd0;
  localparam logic [2:0] COUNT_1  = 3'd1;
  localparam logic [2:0] COMP_2ND = 3'd2;
  localparam logic [2:0] LOCKED   = 3'd3;
  localparam logic [2:0] COUNT_LK = 3'd4;
  localparam logic [2:0] COMP_LK  = 3'd5;
  function automatic logic [23:0] am_pattern(input int lane);
    case (lane)
      0:  return 24'hC16821;
      1:  return 24'h9D718E;
      2:  return 24'h594BE8;
      3:  return 24'h4D957B;
      4:  return 24'hF50709;
      5:  return 24'hDD14C2;
      6:  return 24'h9A4A26;
      7:  return 24'h7B4566;
      8:  return 24'hA02476;
      9:  return 24'h68C9FB;
      10: return 24'hFD6C99;
      11: return 24'hB99155;
      12: return 24'h5CB9B2;
      13: return 24'h1AF8BD;
      14: return 24'h83C7CA;
      15: return 24'h3536CD;
      16: return 24'hC4314C;
      17: return 24'hADD6B7;
      18: return 24'h5F662A;
      19: return 24'hC0F0E5;
      default: return 24'h000000;
    endcase
  endfunction
  // Fixed (non-BIP) marker bytes in block order: M0 M1 M2 M4 M5 M6
  function automatic logic [47:0] am_fixed(input int lane);
    return {am_pattern(lane), ~am_pattern(lane)};
  endfunction
endpackage

// File: rtl/am_lock_module_match.sv
// am_match: combinational 20-way alignment-marker comparator
//   data    - 66-bit coded block
//   hit     - block is a control block carrying one lane's marker
//   lane_id - index of the matching lane (0 when no hit)
module am_match
  import am_lock_pkg::*;
#(
  parameter int NB_DATA    = 66,
  parameter int N_LANES    = N_LANES_DFLT,
  parameter int NB_LANE_ID = $clog2(N_LANES)
)(
  input  logic [NB_DATA-1:0]    data,
  output logic                  hit,
  output logic [NB_LANE_ID-1:0] lane_id
);
  logic [N_LANES-1:0] hits;
  logic               unused_bip;
  // BIP3 and BIP7 carry parity, not identity, so they never take part in the match
  assign unused_bip = ^{data[39:32], data[7:0]};
  for (genvar i = 0; i < N_LANES; i++) begin : g_lane
    assign hits[i] = (data[NB_DATA-1 -: 2] == 2'b10) && ({data[63:40], data[31:8]} == am_fixed(i));
  end
  // Patterns are mutually exclusive, so OR-ing the indices of set hits is a valid encoder
  always_comb begin
    lane_id = '0;
    for (int i = 0; i < N_LANES; i++) lane_id = lane_id | (hits[i] ? NB_LANE_ID'(i) : '0);
  end
  assign hit = |hits;
endmodule

// File: rtl/am_lock_module.sv
// am_lock_module: per-lane AM search, lane identification and AM lock FSM
//   i_clock, i_reset (async active-low), i_enable (global hold when low)
//   i_valid, i_block_lock, i_data  - block stream from the block synchroniser
//   o_data, o_valid                - block stream delayed by one cycle
//   o_am_flag                      - marks the expected AM block while locked
//   o_lane_id, o_am_lock           - detected PCS lane and lock status
module am_lock_module
  import am_lock_pkg::*;
#(
  parameter int NB_DATA       = 66,
  parameter int N_LANES       = N_LANES_DFLT,
  parameter int NB_LANE_ID    = $clog2(N_LANES),
  parameter int AM_PERIOD     = AM_PERIOD_DFLT,
  parameter int NB_PERIOD_CNT = $clog2(AM_PERIOD),
  parameter int MAX_INV_AM    = MAX_INV_AM_DFLT
)(
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_enable,
  input  logic                  i_valid,
  input  logic                  i_block_lock,
  input  logic [NB_DATA-1:0]    i_data,
  output logic [NB_DATA-1:0]    o_data,
  output logic                  o_valid,
  output logic                  o_am_flag,
  output logic [NB_LANE_ID-1:0] o_lane_id,
  output logic                  o_am_lock
);
  localparam int NB_INV = $clog2(MAX_INV_AM + 1);
  localparam logic [NB_INV-1:0] INV_MAX = NB_INV'(MAX_INV_AM);
  localparam logic [NB_PERIOD_CNT-1:0] CNT_LAST = NB_PERIOD_CNT'(AM_PERIOD - 2);
  logic                     hit;
  logic [NB_LANE_ID-1:0]    hit_lane;
  logic [2:0]               state;
  logic [NB_PERIOD_CNT-1:0] period_cnt;
  logic [NB_INV-1:0]        inv_cnt;
  logic [NB_INV-1:0]        inv_next;
  logic                     same;
  logic                     period_end;
  am_match #(
    .NB_DATA    (NB_DATA),
    .N_LANES    (N_LANES),
    .NB_LANE_ID (NB_LANE_ID)
  ) u_match (
    .data    (i_data),
    .hit     (hit),
    .lane_id (hit_lane)
  );
  assign same       = hit && (hit_lane == o_lane_id);
  // Counter starts at 0 on the block after an AM; at AM_PERIOD-2 the next block is the compare slot
  assign period_end = period_cnt == CNT_LAST;
  assign inv_next   = (inv_cnt == INV_MAX) ? inv_cnt : inv_cnt + NB_INV'(1);
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state      <= FIND_1ST;
      period_cnt <= '0;
      inv_cnt    <= '0;
      o_data     <= '0;
      o_valid    <= 1'b0;
      o_am_flag  <= 1'b0;
      o_lane_id  <= '0;
      o_am_lock  <= 1'b0;
    end else if (i_enable) begin
      o_data    <= i_data;
      o_valid   <= i_valid;
      o_am_flag <= 1'b0;
      if (!i_block_lock) begin
        state      <= FIND_1ST;
        period_cnt <= '0;
        inv_cnt    <= '0;
        o_am_lock  <= 1'b0;
      end else if (i_valid) begin
        case (state)
          FIND_1ST: begin
            if (hit) begin
              o_lane_id  <= hit_lane;
              period_cnt <= '0;
              inv_cnt    <= '0;
              state      <= COUNT_1;
            end
          end
          COUNT_1, COUNT_LK: begin
            period_cnt <= period_cnt + NB_PERIOD_CNT'(1);
            if (period_end) state <= (state == COUNT_1) ? COMP_2ND : COMP_LK;
          end
          COMP_2ND: begin
            period_cnt <= '0;
            o_am_lock  <= same;
            state      <= same ? LOCKED : FIND_1ST;
          end
          LOCKED: begin
            period_cnt <= period_cnt + NB_PERIOD_CNT'(1);
            state      <= COUNT_LK;
          end
          COMP_LK: begin
            period_cnt <= '0;
            o_am_flag  <= same;
            inv_cnt    <= same ? '0 : inv_next;
            if (!same && inv_next == INV_MAX) begin
              o_am_lock <= 1'b0;
              state     <= FIND_1ST;
            end else begin
              state <= COUNT_LK;
            end
          end
          default: state <= FIND_1ST;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_am_lock_module.sv
// tb_am_lock_module: self-checking bench for am_lock_module with a short AM period
module tb_am_lock_module;
  localparam int P = 64;
  localparam logic [23:0] TBL [20] = '{
    24'hC16821, 24'h9D718E, 24'h594BE8, 24'h4D957B, 24'hF50709,
    24'hDD14C2, 24'h9A4A26, 24'h7B4566, 24'hA02476, 24'h68C9FB,
    24'hFD6C99, 24'hB99155, 24'h5CB9B2, 24'h1AF8BD, 24'h83C7CA,
    24'h3536CD, 24'hC4314C, 24'hADD6B7, 24'h5F662A, 24'hC0F0E5};
  typedef struct {
    string       name;
    logic [65:0] data;
    logic [4:0]  lane;
  } vec_t;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        v = 1'b0;
  logic        bl = 1'b0;
  logic [65:0] din = '0;
  logic [65:0] o_data;
  logic        o_valid, o_am_flag, o_am_lock;
  logic [4:0]  o_lane_id;
  int checks = 0;
  int failures = 0;
  int m_mode, m_since, m_bad;
  logic [65:0] e_data;
  logic        e_valid, e_flag, e_lock;
  logic [4:0]  e_lane;
  vec_t vec[8];

  am_lock_module #(.AM_PERIOD(P)) dut (
    .i_clock(clk), .i_reset(rst_n), .i_enable(en), .i_valid(v), .i_block_lock(bl),
    .i_data(din), .o_data(o_data), .o_valid(o_valid), .o_am_flag(o_am_flag),
    .o_lane_id(o_lane_id), .o_am_lock(o_am_lock));

  always #5 clk = ~clk;

  function automatic logic [65:0] mk(input int lane, input logic [1:0] hdr, input logic [7:0] m1x);
    logic [23:0] p = TBL[lane];
    return {hdr, p[23:16], p[15:8] ^ m1x, p[7:0], 8'($urandom), ~p, 8'($urandom)};
  endfunction

  function automatic logic [65:0] rnd();
    return {2'b01, $urandom, $urandom};
  endfunction

  function automatic int lane_of(input logic [65:0] d);
    for (int i = 0; i < 20; i++)
      if (d[65:64] == 2'b10 && d[63:40] == TBL[i] && d[31:8] == ~TBL[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_since = 0; m_bad = 0;
    e_data = '0; e_valid = 0; e_flag = 0; e_lock = 0; e_lane = '0;
  endtask

  // Reference: an AM is expected exactly P valid blocks after the anchoring AM
  task automatic model();
    int l;
    bit good;
    if (!en) return;
    e_data = din; e_valid = v; e_flag = 0;
    if (!bl) begin m_mode = 0; m_bad = 0; e_lock = 0; return; end
    if (!v) return;
    l = lane_of(din);
    if (m_mode == 0) begin
      if (l >= 0) begin m_mode = 1; e_lane = 5'(l); m_since = 0; end
      return;
    end
    m_since++;
    if (m_since != P) return;
    m_since = 0;
    good = (l == int'(e_lane));
    if (m_mode == 1) begin
      m_mode = good ? 2 : 0; e_lock = good; m_bad = 0;
    end else if (good) begin
      m_bad = 0; e_flag = 1;
    end else begin
      m_bad++;
      if (m_bad == 4) begin m_mode = 0; e_lock = 0; end
    end
  endtask

  task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic ve, input logic [65:0] d);
    v = ve; din = d;
    @(posedge clk);
    model();
    #1;
    checks++;
    if ({o_data, o_valid, o_am_flag, o_lane_id, o_am_lock} !== {e_data, e_valid, e_flag, e_lane, e_lock}) begin
      failures++;
      $display("FAIL model t=%0t got data=%h v=%b flag=%b lane=%0d lock=%b expected data=%h v=%b flag=%b lane=%0d lock=%b",
               $time, o_data, o_valid, o_am_flag, o_lane_id, o_am_lock, e_data, e_valid, e_flag, e_lane, e_lock);
    end
  endtask

  task automatic blk(input logic [65:0] d);
    step(1'b1, d);
  endtask

  task automatic fill(input int n);
    repeat (n) step(1'b1, rnd());
  endtask

  task automatic sync_reset();
    rst_n = 1'b0; model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [65:0] d;
    logic [65:0] prev;
    int g, vb, lane, r;
    logic ve;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_data", o_data, 66'd0);
    chk("reset_valid", o_valid, 1'b0);
    chk("reset_flag", o_am_flag, 1'b0);
    chk("reset_lane", o_lane_id, 5'd0);
    chk("reset_lock", o_am_lock, 1'b0);
    rst_n = 1'b1; en = 1'b1; bl = 1'b1;

    vec[0] = '{"match_lane1", mk(1, 2'b10, 8'h00), 5'd1};
    vec[1] = '{"match_lane5", mk(5, 2'b10, 8'h00), 5'd5};
    vec[2] = '{"match_lane12", mk(12, 2'b10, 8'h00), 5'd12};
    vec[3] = '{"bad_header01", mk(9, 2'b01, 8'h00), 5'd0};
    vec[4] = '{"bad_m1", mk(13, 2'b10, 8'h40), 5'd0};
    vec[5] = '{"bad_m6", mk(7, 2'b10, 8'h00) ^ {50'd0, 8'hFF, 8'd0}, 5'd0};
    vec[6] = '{"match_lane3", mk(3, 2'b10, 8'h00), 5'd3};
    vec[7] = '{"bad_header11", mk(14, 2'b11, 8'h00), 5'd0};
    for (int i = 0; i < 8; i++) begin
      sync_reset();
      blk(vec[i].data);
      chk(vec[i].name, o_lane_id, vec[i].lane);
      chk("tbl_data", o_data, vec[i].data);
    end

    // Lock on lane 0 and AM flag positions
    sync_reset();
    blk(mk(0, 2'b10, 0));
    fill(63);
    chk("no_lock_before_2nd_am", o_am_lock, 1'b0);
    blk(mk(0, 2'b10, 0));
    chk("lock_after_2nd_am", o_am_lock, 1'b1);
    chk("lane_id_0", o_lane_id, 5'd0);
    chk("no_flag_on_2nd_am", o_am_flag, 1'b0);
    fill(63);
    chk("no_flag_before_am", o_am_flag, 1'b0);
    d = mk(0, 2'b10, 0);
    blk(d);
    chk("flag_at_128", o_am_flag, 1'b1);
    chk("flag_data_aligned", o_data, d);
    fill(1);
    chk("flag_one_block", o_am_flag, 1'b0);
    fill(62);
    blk(mk(0, 2'b10, 0));
    chk("flag_at_192", o_am_flag, 1'b1);

    // Three bad AMs then a good one keep lock; four bad AMs lose it
    for (int k = 0; k < 3; k++) begin
      fill(63);
      blk(mk(0, 2'b10, 8'h01));
      chk("lock_held_bad", o_am_lock, 1'b1);
      chk("no_flag_bad", o_am_flag, 1'b0);
    end
    fill(63);
    blk(mk(0, 2'b10, 0));
    chk("good_after_3_bad_flag", o_am_flag, 1'b1);
    chk("good_after_3_bad_lock", o_am_lock, 1'b1);
    for (int k = 0; k < 4; k++) begin
      fill(63);
      blk(mk(0, 2'b10, 8'h01));
      chk("lock_vs_bad_count", o_am_lock, (k < 3) ? 1'b1 : 1'b0);
    end

    // False first hit on lane 1
    sync_reset();
    blk(mk(1, 2'b10, 0));
    chk("false_first_lane", o_lane_id, 5'd1);
    fill(63);
    blk(mk(0, 2'b10, 0));
    chk("false_no_lock", o_am_lock, 1'b0);
    chk("false_no_relatch", o_lane_id, 5'd1);
    fill(63);
    blk(mk(0, 2'b10, 0));
    chk("refind_no_lock", o_am_lock, 1'b0);
    chk("refind_lane0", o_lane_id, 5'd0);
    fill(63);
    blk(mk(0, 2'b10, 0));
    chk("relock_lane0", o_am_lock, 1'b1);

    // Block-lock drop coinciding with a good AM
    fill(63);
    bl = 1'b0;
    blk(mk(0, 2'b10, 0));
    bl = 1'b1;
    chk("bl_drop_lock", o_am_lock, 1'b0);
    chk("bl_drop_flag", o_am_flag, 1'b0);
    fill(63);
    blk(mk(0, 2'b10, 0));
    chk("bl_restart_first", o_am_lock, 1'b0);
    fill(63);
    blk(mk(0, 2'b10, 0));
    chk("bl_restart_lock", o_am_lock, 1'b1);

    // Enable low holds outputs
    prev = o_data;
    en = 1'b0;
    step(1'b1, rnd());
    chk("enable_hold_data", o_data, prev);
    chk("enable_hold_lock", o_am_lock, 1'b1);
    en = 1'b1;

    // Valid gaps shift the lock instant only by the gap count
    sync_reset();
    blk(mk(4, 2'b10, 0));
    g = 0;
    for (int i = 0; i < 63; i++) begin
      if ($urandom_range(2) == 0) begin
        step(1'b0, rnd());
        chk("gap_valid_low", o_valid, 1'b0);
        g++;
      end
      blk(rnd());
    end
    chk("gap_no_lock_yet", o_am_lock, 1'b0);
    blk(mk(4, 2'b10, 0));
    chk("gap_lock", o_am_lock, 1'b1);
    chk("gap_lane4", o_lane_id, 5'd4);

    // Asynchronous reset between edges while locked
    fill(10);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_data", o_data, 66'd0);
    chk("async_valid", o_valid, 1'b0);
    chk("async_flag", o_am_flag, 1'b0);
    chk("async_lane", o_lane_id, 5'd0);
    chk("async_lock", o_am_lock, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    blk(mk(2, 2'b10, 0));
    fill(63);
    chk("async_relock_wait", o_am_lock, 1'b0);
    blk(mk(2, 2'b10, 0));
    chk("async_relock", o_am_lock, 1'b1);
    chk("async_relock_lane", o_lane_id, 5'd2);

    // Randomized stream against the reference model
    sync_reset();
    lane = $urandom_range(19);
    vb = 0;
    for (int n = 0; n < 3000; n++) begin
      en = ($urandom_range(29) != 0);
      bl = ($urandom_range(499) != 0);
      ve = ($urandom_range(9) != 0);
      if (ve && en && (vb % P == 0)) begin
        r = $urandom_range(9);
        d = (r < 7) ? mk(lane, 2'b10, 0) :
            (r < 9) ? mk(lane, 2'b10, 8'(1 << $urandom_range(7))) : mk((lane + 1) % 20, 2'b10, 0);
      end else begin
        d = {2'($urandom), $urandom, $urandom};
      end
      if (ve && en) vb++;
      step(ve, d);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
